// File: rtl/pmic_pwm_gen_pkg.sv
// Shared definitions for the PMIC complementary PWM generator: state encodings,
// default widths and the control FSM next-state function.
package pmic_pwm_gen_pkg;

    localparam int unsigned DefWidth   = 8;
    localparam int unsigned DefDtWidth = 4;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_FAULT = 2'b10;

    // fault has top priority; FAULT only exits to IDLE, never straight to RUN
    function automatic logic [1:0] fsm_next(
        input logic [1:0] state,
        input logic       en,
        input logic       fault,
        input logic       fault_clr
    );
        logic [1:0] nxt;
        nxt = state;
        if (fault) begin
            nxt = ST_FAULT;
        end else begin
            case (state)
                ST_IDLE:  if (en)         nxt = ST_RUN;
                ST_RUN:   if (!en)        nxt = ST_IDLE;
                ST_FAULT: if (fault_clr)  nxt = ST_IDLE;
                default:                  nxt = ST_IDLE;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pmic_deadtime.sv
// Dead-time insertion stage: turns the raw PWM level into non-overlapping
// high-side / low-side drives with a programmable both-low gap.
module pmic_deadtime
    import pmic_pwm_gen_pkg::*;
#(
    parameter int unsigned DT_WIDTH = DefDtWidth
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                pwm_raw,
    input  logic [DT_WIDTH-1:0] dead,
    input  logic                run,
    input  logic                start,
    output logic                hs_out,
    output logic                ls_out
);

    logic                lvl_q, lvl_d;
    logic [DT_WIDTH-1:0] dt_q, dt_d;
    logic                hs_q, hs_d;
    logic                ls_q, ls_d;

    always_comb begin
        lvl_d = lvl_q;
        dt_d  = dt_q;
        hs_d  = 1'b0;
        ls_d  = 1'b0;
        if (!run) begin
            lvl_d = 1'b0;
            dt_d  = '0;
        end else if (start) begin
            // Entry always starts from a low level with a full dead-time gap
            lvl_d = 1'b0;
            dt_d  = dead;
        end else begin
            if (pwm_raw != lvl_q) begin
                lvl_d = pwm_raw;
                dt_d  = dead;
            end else if (dt_q != '0) begin
                dt_d = dt_q - DT_WIDTH'(1);
            end
            hs_d = lvl_d  && (dt_d == '0);
            ls_d = !lvl_d && (dt_d == '0);
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            lvl_q <= 1'b0;
            dt_q  <= '0;
            hs_q  <= 1'b0;
            ls_q  <= 1'b0;
        end else begin
            lvl_q <= lvl_d;
            dt_q  <= dt_d;
            hs_q  <= hs_d;
            ls_q  <= ls_d;
        end
    end

    assign hs_out = hs_q;
    assign ls_out = ls_q;

endmodule

// File: rtl/pmic_pwm_gen.sv
// Complementary PWM generator: control FSM, period counter and shadowed
// duty/period registers feeding the dead-time stage.
module pmic_pwm_gen
    import pmic_pwm_gen_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned DT_WIDTH = DefDtWidth
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                en,
    input  logic [WIDTH-1:0]    duty,
    input  logic [WIDTH-1:0]    period,
    input  logic [DT_WIDTH-1:0] dead,
    input  logic                fault,
    input  logic                fault_clr,
    output logic                hs_out,
    output logic                ls_out,
    output logic                period_start,
    output logic                fault_flag
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic [WIDTH-1:0] period_sh_q, period_sh_d;
    logic             period_start_q, period_start_d;
    logic             fault_flag_q, fault_flag_d;

    logic in_run;
    logic run_next;
    logic start;
    logic wrap;
    logic pwm_raw;

    always_comb begin
        state_d  = fsm_next(state_q, en, fault, fault_clr);
        in_run   = (state_q == ST_RUN);
        run_next = (state_d == ST_RUN);
        start    = run_next && !in_run;
        wrap     = in_run && (pcnt_q == period_sh_q);
        pwm_raw  = in_run && (pcnt_q < duty_sh_q);
    end

    always_comb begin
        pcnt_d      = '0;
        duty_sh_d   = duty_sh_q;
        period_sh_d = period_sh_q;
        if (run_next && !start && !wrap) begin
            pcnt_d = pcnt_q + WIDTH'(1);
        end
        // Shadows only move at period boundaries so a period is never torn
        if (start || wrap) begin
            duty_sh_d   = duty;
            period_sh_d = period;
        end
        period_start_d = run_next && (pcnt_d == '0);
        fault_flag_d   = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q        <= ST_IDLE;
            pcnt_q         <= '0;
            duty_sh_q      <= '0;
            period_sh_q    <= '0;
            period_start_q <= 1'b0;
            fault_flag_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pcnt_q         <= pcnt_d;
            duty_sh_q      <= duty_sh_d;
            period_sh_q    <= period_sh_d;
            period_start_q <= period_start_d;
            fault_flag_q   <= fault_flag_d;
        end
    end

    pmic_deadtime #(
        .DT_WIDTH (DT_WIDTH)
    ) u_deadtime (
        .clk     (clk),
        .clear   (clear),
        .pwm_raw (pwm_raw),
        .dead    (dead),
        .run     (run_next),
        .start   (start),
        .hs_out  (hs_out),
        .ls_out  (ls_out)
    );

    assign period_start = period_start_q;
    assign fault_flag   = fault_flag_q;

endmodule

// File: tb/tb_pmic_pwm_gen.sv
// Self-checking bench for pmic_pwm_gen: directed runs with a per-cycle
// expected-output scoreboard plus a continuous drive-overlap checker.
module tb_pmic_pwm_gen;

    typedef struct packed {
        logic hs;
        logic ls;
        logic ps;
    } exp_t;

    logic       clk = 1'b0;
    logic       clear;
    logic       en;
    logic [7:0] duty;
    logic [7:0] period;
    logic [3:0] dead;
    logic       fault;
    logic       fault_clr;
    logic       hs_out;
    logic       ls_out;
    logic       period_start;
    logic       fault_flag;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    pmic_pwm_gen #(
        .WIDTH    (8),
        .DT_WIDTH (4)
    ) dut (
        .clk          (clk),
        .clear        (clear),
        .en           (en),
        .duty         (duty),
        .period       (period),
        .dead         (dead),
        .fault        (fault),
        .fault_clr    (fault_clr),
        .hs_out       (hs_out),
        .ls_out       (ls_out),
        .period_start (period_start),
        .fault_flag   (fault_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        total++;
        assert ((hs_out & ls_out) === 1'b0) else begin
            bad++;
            $error("FAIL overlap observed hs=%b ls=%b required not both high", hs_out, ls_out);
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raw PWM level in the cycle j clocks after RUN entry (j = -1 is the reset level)
    function automatic logic raw_at(input int j, input int d0, input int d1, input int p);
        int pl;
        int d;
        if (j < 0) return 1'b0;
        pl = p + 1;
        d  = ((j / pl) == 0) ? d0 : d1;
        return (j % pl) < d;
    endfunction

    function automatic exp_t model(input int j, input int d0, input int d1, input int p,
                                   input int dt);
        exp_t e;
        int   m;
        logic lvl;
        logic ok;
        e.ps = ((j % (p + 1)) == 0);
        if (j == 0) begin
            e.hs = 1'b0;
            e.ls = 1'b0;
            return e;
        end
        m = -1;
        for (int i = j - 1; i >= 0; i--) begin
            if (raw_at(i, d0, d1, p) != raw_at(i - 1, d0, d1, p)) begin
                m = i;
                break;
            end
        end
        lvl  = raw_at(j - 1, d0, d1, p);
        ok   = ((j - 1 - m) >= dt);
        e.hs = lvl && ok;
        e.ls = !lvl && ok;
        return e;
    endfunction

    // Enter RUN from IDLE and check n cycles; duty switches to d1 after cycle chg_at
    task automatic run_seg(input string tag, input int d0, input int d1, input int p,
                           input int dt, input int n, input int chg_at);
        exp_t e;
        duty   = 8'(d0);
        period = 8'(p);
        dead   = 4'(dt);
        en     = 1'b1;
        for (int j = 0; j < n; j++) sb.push_back(model(j, d0, d1, p, dt));
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("%s hs j=%0d", tag, j), {7'b0, hs_out}, {7'b0, e.hs});
            check($sformatf("%s ls j=%0d", tag, j), {7'b0, ls_out}, {7'b0, e.ls});
            check($sformatf("%s ps j=%0d", tag, j), {7'b0, period_start}, {7'b0, e.ps});
            if (j == chg_at) duty = 8'(d1);
        end
    endtask

    task automatic stop_run(input string tag);
        en = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " stop hs"}, {7'b0, hs_out}, 8'h00);
        check({tag, " stop ls"}, {7'b0, ls_out}, 8'h00);
        check({tag, " stop ps"}, {7'b0, period_start}, 8'h00);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear     = 1'b0;
        en        = 1'b0;
        duty      = 8'd0;
        period    = 8'd0;
        dead      = 4'd0;
        fault     = 1'b0;
        fault_clr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset hs", {7'b0, hs_out}, 8'h00);
        check("reset ls", {7'b0, ls_out}, 8'h00);
        check("reset ps", {7'b0, period_start}, 8'h00);
        check("reset flag", {7'b0, fault_flag}, 8'h00);
        clear = 1'b1;
        @(posedge clk);
        #1;

        run_seg("d3 dead0", 3, 3, 9, 0, 32, -1);
        stop_run("d3 dead0");
        run_seg("d3 dead2", 3, 3, 9, 2, 32, -1);
        stop_run("d3 dead2");
        run_seg("shadow", 3, 6, 9, 0, 32, 5);
        stop_run("shadow");
        run_seg("d0 dead2", 0, 0, 9, 2, 25, -1);
        stop_run("d0 dead2");
        run_seg("d255 dead2", 255, 255, 9, 2, 25, -1);
        stop_run("d255 dead2");
        run_seg("narrow", 1, 1, 4, 3, 16, -1);
        stop_run("narrow");

        run_seg("pre fault", 3, 3, 9, 0, 2, -1);
        fault = 1'b1;
        @(posedge clk);
        #1;
        check("fault hs", {7'b0, hs_out}, 8'h00);
        check("fault ls", {7'b0, ls_out}, 8'h00);
        check("fault flag", {7'b0, fault_flag}, 8'h01);
        fault_clr = 1'b1;
        @(posedge clk);
        #1;
        check("fault+clr flag", {7'b0, fault_flag}, 8'h01);
        check("fault+clr hs", {7'b0, hs_out}, 8'h00);
        fault = 1'b0;
        @(posedge clk);
        #1;
        check("clr flag", {7'b0, fault_flag}, 8'h00);
        check("clr hs", {7'b0, hs_out}, 8'h00);
        check("clr ls", {7'b0, ls_out}, 8'h00);
        check("clr ps", {7'b0, period_start}, 8'h00);
        fault_clr = 1'b0;
        run_seg("post fault", 3, 3, 9, 2, 22, -1);

        stop_run("pre async");
        run_seg("pre async", 3, 3, 9, 0, 2, -1);
        #2;
        clear = 1'b0;
        #1;
        check("async hs", {7'b0, hs_out}, 8'h00);
        check("async ls", {7'b0, ls_out}, 8'h00);
        en    = 1'b0;
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("after async hs", {7'b0, hs_out}, 8'h00);
        check("after async ps", {7'b0, period_start}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
